input_debouncer: RTL and testbench

- Front-end conditioning stage for asynchronous, bouncy single-bit inputs such as switches and external strobes.
- Synchronizes `raw_in` into the `clock` domain and filters out pulses shorter than a programmable number of cycles.
- Drives a clean, glitch-free level on `data_out`, which connects directly to the `data` input of the positive edge detector.
- The edge detector therefore sees exactly one rising transition per debounced press.

---
 rtl/input_debouncer_pkg.sv | 21 ++
 rtl/input_debouncer_sync_chain.sv | 31 +++
 rtl/input_debouncer.sv | 127 ++++++++++++
 tb/tb_input_debouncer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer_pkg
// Brief    : Shared state encoding and default constants for input_debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        RISE_PEND = 2'b01,
        HIGH      = 2'b10,
        FALL_PEND = 2'b11
    } deb_state_t;

    localparam int         SYNC_STAGES_DEF     = 2;
    localparam int         DEBOUNCE_CYCLES_DEF = 4;
    localparam logic [7:0] GLITCH_CNT_MAX      = 8'd255;

endpackage
`default_nettype wire

// File: rtl/input_debouncer_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : SYNC_STAGES-deep flip-flop synchronizer with synchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Brief    : Synchronizes and debounces a raw input; optional glitch counter
//            enabled by INPUT_DEBOUNCER_GLITCH_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       raw_in,
    output logic       data_out,
    output logic       busy
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_s;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_data_out;
    logic             r_busy;

    sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .clock (clock),
        .reset (reset),
        .d     (raw_in),
        .q     (w_s)
    );

    // Outputs are assigned alongside the state so they track it with no decode glitches.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= LOW;
            r_cnt      <= '0;
            r_data_out <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                LOW: begin
                    if (w_s) begin
                        r_state <= RISE_PEND;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                RISE_PEND: begin
                    if (!w_s) begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state    <= HIGH;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_data_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!w_s) begin
                        r_state <= FALL_PEND;
                        r_cnt   <= CNT_W'(1);
                        r_busy  <= 1'b1;
                    end
                end
                FALL_PEND: begin
                    if (w_s) begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state    <= LOW;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_data_out <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= LOW;
                    r_cnt      <= '0;
                    r_busy     <= 1'b0;
                    r_data_out <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign busy     = r_busy;

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic       w_glitch;
    logic [7:0] r_glitch_count;

    // A pending change abandoned before confirmation is a rejected pulse.
    assign w_glitch = ((r_state == RISE_PEND) && !w_s) ||
                      ((r_state == FALL_PEND) &&  w_s);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_glitch_count <= 8'd0;
        end else if (w_glitch && (r_glitch_count != GLITCH_CNT_MAX)) begin
            r_glitch_count <= r_glitch_count + 8'd1;
        end
    end

    assign glitch_count = r_glitch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_debouncer
// Brief    : Self-checking bench for input_debouncer against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int N    = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       raw_in;
    logic       data_out;
    logic       busy;
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    input_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .raw_in       (raw_in),
        .data_out     (data_out),
        .busy         (busy)
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_count (glitch_count)
`endif
    );

    // Reference: the output flips once the synchronized input has disagreed
    // with it for N samples in a row; an interrupted run is a glitch.
    logic m_pipe[$];
    logic m_s;
    logic m_out;
    logic m_busy;
    int   m_run;
    int   m_glitch;

    always @(posedge clock) begin
        if (reset) begin
            m_pipe.delete();
            for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
            m_out    = 1'b0;
            m_run    = 0;
            m_glitch = 0;
        end else begin
            m_s = m_pipe.pop_front();
            m_pipe.push_back(raw_in);
            if (m_s != m_out) begin
                m_run++;
                if (m_run == N) begin
                    m_out = m_s;
                    m_run = 0;
                end
            end else if (m_run != 0) begin
                m_run = 0;
                if (m_glitch < 255) m_glitch++;
            end
        end
        m_busy = (m_run != 0);
    end

    task automatic tick(input logic v);
        raw_in = v;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int rise;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            checks++;
            if (data_out !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d data_out=%b busy=%b expected 0 0", i, data_out, busy);
            end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
            checks++;
            if (glitch_count !== 8'd0) begin
                errors++;
                $display("FAIL reset_glitch cyc=%0d got=%0d expected 0", i, glitch_count);
            end
`endif
        end
        reset = 1'b0;
        rise  = -1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            checks++;
            if (data_out !== m_out || busy !== m_busy) begin
                errors++;
                $display("FAIL reset_release edge=%0d data_out=%b busy=%b expected %b %b", i, data_out, busy, m_out, m_busy);
            end
            if (data_out === 1'b1 && rise < 0) rise = i;
        end
        checks++;
        if (rise != 5) begin
            errors++;
            $display("FAIL reset_rise_edge got=%0d expected 5", rise);
        end
    endtask

    task automatic test_clean_press();
        int busy_e, rise, fall;
        for (int i = 0; i < 10; i++) tick(1'b0);
        busy_e = -1;
        rise   = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            checks++;
            if (data_out !== m_out || busy !== m_busy) begin
                errors++;
                $display("FAIL press edge=%0d data_out=%b busy=%b expected %b %b", i, data_out, busy, m_out, m_busy);
            end
            if (busy === 1'b1 && busy_e < 0) busy_e = i;
            if (data_out === 1'b1 && rise < 0) rise = i;
        end
        checks++;
        if (busy_e != 2 || rise != 5) begin
            errors++;
            $display("FAIL press_timing busy_edge=%0d rise_edge=%0d expected 2 5", busy_e, rise);
        end
        fall = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            checks++;
            if (data_out !== m_out || busy !== m_busy) begin
                errors++;
                $display("FAIL release edge=%0d data_out=%b busy=%b expected %b %b", i, data_out, busy, m_out, m_busy);
            end
            if (data_out === 1'b0 && fall < 0) fall = i;
        end
        checks++;
        if (fall != 5) begin
            errors++;
            $display("FAIL release_timing fall_edge=%0d expected 5", fall);
        end
    endtask

    task automatic test_bounce();
        logic pat [14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bit seen_high = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(pat[i]);
            checks++;
            if (data_out !== m_out || busy !== m_busy) begin
                errors++;
                $display("FAIL bounce cyc=%0d data_out=%b busy=%b expected %b %b", i, data_out, busy, m_out, m_busy);
            end
            if (data_out !== 1'b0) seen_high = 1'b1;
        end
        checks++;
        if (seen_high) begin
            errors++;
            $display("FAIL bounce_level data_out went high, expected stay 0");
        end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        checks++;
        if (glitch_count !== 8'd2) begin
            errors++;
            $display("FAIL bounce_glitches got=%0d expected 2", glitch_count);
        end
`endif
    endtask

    task automatic test_boundary();
        int lens   [2] = '{4, 3};
        int exp_hi [2] = '{4, 0};
        int exp_gl [2] = '{0, 1};
        int hi;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            for (int i = 0; i < lens[p] + 12; i++) begin
                tick(i < lens[p] ? 1'b1 : 1'b0);
                checks++;
                if (data_out !== m_out || busy !== m_busy) begin
                    errors++;
                    $display("FAIL boundary len=%0d cyc=%0d data_out=%b busy=%b expected %b %b", lens[p], i, data_out, busy, m_out, m_busy);
                end
                if (data_out === 1'b1) hi++;
            end
            checks++;
            if (hi != exp_hi[p]) begin
                errors++;
                $display("FAIL boundary_width len=%0d high_cycles=%0d expected %0d", lens[p], hi, exp_hi[p]);
            end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
            checks++;
            if (glitch_count !== 8'(exp_gl[p])) begin
                errors++;
                $display("FAIL boundary_glitches len=%0d got=%0d expected %0d", lens[p], glitch_count, exp_gl[p]);
            end
`else
            if (exp_gl[p] < 0) $display("unexpected glitch table entry");
`endif
        end
    endtask

    task automatic test_mid_reset();
        int rise;
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1);
        checks++;
        if (busy !== 1'b1 || data_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_pending busy=%b data_out=%b expected 1 0", busy, data_out);
        end
        reset = 1'b1;
        tick(1'b1);
        checks++;
        if (busy !== 1'b0 || data_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy=%b data_out=%b expected 0 0", busy, data_out);
        end
        reset = 1'b0;
        rise  = -1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            if (data_out === 1'b1 && rise < 0) rise = i;
        end
        checks++;
        if (rise != 5) begin
            errors++;
            $display("FAIL mid_reset_restart rise_edge=%0d expected 5", rise);
        end
    endtask

    task automatic test_random();
        logic lvl = 1'b0;
        int   len;
        int   n = 0;
        do_reset();
        while (n < 500) begin
            lvl = ~lvl;
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                tick(lvl);
                n++;
                checks++;
                if (data_out !== m_out || busy !== m_busy) begin
                    errors++;
                    $display("FAIL random cyc=%0d data_out=%b busy=%b expected %b %b", n, data_out, busy, m_out, m_busy);
                end
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
                checks++;
                if (glitch_count !== 8'(m_glitch)) begin
                    errors++;
                    $display("FAIL random_glitches cyc=%0d got=%0d expected %0d", n, glitch_count, m_glitch);
                end
`endif
            end
        end
    endtask

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick(1'b1);
            tick(1'b0);
        end
        for (int i = 0; i < 4; i++) tick(1'b0);
        checks++;
        if (glitch_count !== 8'd255 || data_out !== 1'b0) begin
            errors++;
            $display("FAIL saturation glitch_count=%0d data_out=%b expected 255 0", glitch_count, data_out);
        end
    endtask
`endif

    initial begin
        reset  = 1'b1;
        raw_in = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_boundary();
        test_mid_reset();
        test_random();
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
